cdwa: RTL and testbench
=======================

CDWA -- requirements
Module: cdwa

Interface
REQ-001 SHALL have parameter NCH, default 3, number of write requesters (2..16).
REQ-002 SHALL have parameter BANKBITS, default 5, bank-select address bits.
REQ-003 SHALL have parameter WORDBITS, default 9, word-in-bank address bits.
REQ-004 SHALL have parameter DATABITS, default 32, write-data width.
REQ-005 SHALL have parameter MODE, default 0, arbitration mode: 0 fixed priority (channel 0 highest), 1 round-robin.
REQ-006 SHALL derive local A = BANKBITS+WORDBITS and CW = max(1, clog2(NCH)).
REQ-007 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have i_en  input  NCH  per-channel write request; bit k = channel k.
REQ-010 SHALL have i_addr  input  NCH*A  packed addresses; channel k at bits [k*A +: A].
REQ-011 SHALL have i_data  input  NCH*DATABITS  packed data; channel k at bits [k*DATABITS +: DATABITS].
REQ-012 SHALL have i_grnt  output  NCH  combinational one-hot grant; at most one bit set.
REQ-013 SHALL have o_stall  input  1  downstream backpressure; high blocks all grants and freezes the output stage.
REQ-014 SHALL have o_en  output  1  registered write enable.
REQ-015 SHALL have o_addr  output  A  registered winning address.
REQ-016 SHALL have o_data  output  DATABITS  registered winning data.
REQ-017 SHALL have o_chan  output  CW  registered winning channel index (mux code).
REQ-018 SHALL have cnt_clr  input  1  synchronous clear of conflict counter.
REQ-019 SHALL have o_conflicts  output  16  saturating count of contended cycles.

Function
REQ-020 SHALL assert i_grnt[k] in a cycle only if i_en[k]=1 and o_stall=0; a request is accepted exactly in a cycle its grant is high.
REQ-021 SHALL assert no grant bit when o_stall=1 or i_en=0.
REQ-022 MODE 0 SHALL grant the lowest-index requesting channel.
REQ-023 MODE 1 SHALL grant the first requesting channel searching upward from (ptr+1) mod NCH, wrapping from NCH-1 to 0.
REQ-024 MODE 1 SHALL load ptr with the granted index on each edge with a grant; ptr holds otherwise, including during stall.
REQ-025 SHALL keep ptr at NCH-1 in MODE 0; it has no effect.
REQ-026 On an edge with a grant, SHALL load o_en=1, o_addr/o_data from the winner, o_chan=winner index; latency request-to-output = 1 cycle.
REQ-027 On an edge with o_stall=0 and no grant, SHALL load o_en=0 and hold o_addr, o_data, o_chan.
REQ-028 On an edge with o_stall=1, SHALL hold o_en, o_addr, o_data, o_chan unchanged.
REQ-029 Non-granted requesters SHALL receive no indication other than i_grnt=0; they re-present and are re-arbitrated next cycle.
REQ-030 SHALL increment o_conflicts on an edge where o_stall=0 and two or more i_en bits are set.
REQ-031 SHALL saturate o_conflicts at 16'hFFFF; no wrap.
REQ-032 cnt_clr=1 SHALL set o_conflicts to 0 on that edge, overriding a simultaneous increment.
REQ-033 SHALL contain no combinational path from any input to o_en, o_addr, o_data, o_chan, o_conflicts.

Reset
REQ-034 rst_n=0 SHALL immediately, regardless of clk, force o_en=0, o_addr=0, o_data=0, o_chan=0, o_conflicts=0, ptr=NCH-1.
REQ-035 i_grnt SHALL be 0 while rst_n=0.
REQ-036 Reset asserted mid-operation SHALL discard any in-flight output; first edge after release behaves as post-reset arbitration (channel 0 first in both modes).

Verification
REQ-037 MODE 0, NCH=3: i_en=3'b110 held 3 cycles -> i_grnt=3'b010 each cycle, o_chan=1, o_en=1 one cycle after; o_conflicts=3.
REQ-038 MODE 1, NCH=3, i_en=3'b111 held 6 cycles from reset -> grants 0,1,2,0,1,2; o_chan follows one cycle later.
REQ-039 MODE 1, i_en=3'b101, ptr=0 -> grant channel 2; next cycle grant channel 0 (wrap).
REQ-040 o_stall=1 for 2 cycles with i_en=3'b011 -> i_grnt=0, outputs frozen at prior values, o_conflicts unchanged; on release grant resumes with unchanged ptr.
REQ-041 o_conflicts preloaded to 16'hFFFE, contended 3 cycles -> holds 16'hFFFF; cnt_clr with contention same cycle -> 0.
REQ-042 rst_n pulsed low between edges while o_en=1 -> o_en, o_chan, o_conflicts read 0 before next edge; MODE 1 next grant goes to channel 0.

Source files
------------

// File: rtl/cdwa_if.sv
// Write-port bundle for the cdwa arbiter: requester side (en/addr/data/grant)
// and the registered downstream write port with its stall.
interface cdwa_if #(
   parameter int NCH      = 3,
   parameter int BANKBITS = 5,
   parameter int WORDBITS = 9,
   parameter int DATABITS = 32
);
   localparam int A  = BANKBITS + WORDBITS;
   localparam int CW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]          i_en;
   logic [NCH*A-1:0]        i_addr;
   logic [NCH*DATABITS-1:0] i_data;
   logic [NCH-1:0]          i_grnt;
   logic                    o_stall;
   logic                    o_en;
   logic [A-1:0]            o_addr;
   logic [DATABITS-1:0]     o_data;
   logic [CW-1:0]           o_chan;

   modport master (
      output i_en, i_addr, i_data, o_stall,
      input  i_grnt, o_en, o_addr, o_data, o_chan
   );

   modport slave (
      input  i_en, i_addr, i_data, o_stall,
      output i_grnt, o_en, o_addr, o_data, o_chan
   );
endinterface

// File: rtl/cdwa.sv
// Contended-write arbiter: picks one of NCH write requesters per cycle
// (fixed priority or round-robin), registers the winner, counts contention.
module cdwa #(
   parameter int NCH      = 3,
   parameter int BANKBITS = 5,
   parameter int WORDBITS = 9,
   parameter int DATABITS = 32,
   parameter int MODE     = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   cdwa_if.slave       bus,
   input  logic        cnt_clr,
   output logic [15:0] o_conflicts
);
   localparam int A  = BANKBITS + WORDBITS;
   localparam int CW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;

   logic [CW-1:0]       ptr;
   logic [CW-1:0]       win;
   logic                win_vld;
   logic [CW-1:0]       first_idx;
   logic                first_vld;
   logic [CW-1:0]       above_idx;
   logic                above_vld;
   logic                grant_ok;
   logic [A-1:0]        win_addr;
   logic [DATABITS-1:0] win_data;
   logic                seen_one;
   logic                multi;

   // Round-robin is done as two scans: lowest requester above ptr, else the
   // lowest requester overall; identical to an upward search with wrap.
   always_comb begin
      first_idx = '0;
      first_vld = 1'b0;
      above_idx = '0;
      above_vld = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (bus.i_en[i]) begin
            if (!first_vld) begin
               first_idx = CW'(i);
               first_vld = 1'b1;
            end
            if (!above_vld && (CW'(i) > ptr)) begin
               above_idx = CW'(i);
               above_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      win     = first_idx;
      win_vld = first_vld;
      if (MODE == 1 && above_vld) begin
         win = above_idx;
      end
   end

   assign grant_ok = rst_n & ~bus.o_stall & win_vld;

   always_comb begin
      bus.i_grnt = '0;
      win_addr   = '0;
      win_data   = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (win == CW'(i)) begin
            bus.i_grnt[i] = grant_ok;
            win_addr      = bus.i_addr[i*A +: A];
            win_data      = bus.i_data[i*DATABITS +: DATABITS];
         end
      end
   end

   always_comb begin
      seen_one = 1'b0;
      multi    = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (bus.i_en[i]) begin
            if (seen_one) begin
               multi = 1'b1;
            end
            seen_one = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.o_en   <= 1'b0;
         bus.o_addr <= '0;
         bus.o_data <= '0;
         bus.o_chan <= '0;
         ptr        <= CW'(NCH - 1);
      end else if (!bus.o_stall) begin
         bus.o_en <= win_vld;
         if (win_vld) begin
            bus.o_addr <= win_addr;
            bus.o_data <= win_data;
            bus.o_chan <= win;
            if (MODE == 1) begin
               ptr <= win;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_conflicts <= '0;
      end else if (cnt_clr) begin
         o_conflicts <= '0;
      end else if (!bus.o_stall && multi && (o_conflicts != '1)) begin
         o_conflicts <= o_conflicts + 16'd1;
      end
   end
endmodule

// File: tb/tb_cdwa.sv
// Bench for cdwa: a fixed-priority and a round-robin instance share stimulus
// and are compared every cycle against a behavioural arbitration model.
module tb_cdwa;
   localparam int NCH = 3;
   localparam int BB  = 5;
   localparam int WB  = 9;
   localparam int DB  = 32;
   localparam int A   = BB + WB;
   localparam int CW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic [NCH-1:0]       en = '0;
   logic [NCH*A-1:0]     addr = '0;
   logic [NCH*DB-1:0]    data = '0;
   logic                 stall = 1'b0;
   logic                 clr = 1'b0;
   logic [15:0]          conf0, conf1;

   cdwa_if #(.NCH(NCH), .BANKBITS(BB), .WORDBITS(WB), .DATABITS(DB)) bus0 ();
   cdwa_if #(.NCH(NCH), .BANKBITS(BB), .WORDBITS(WB), .DATABITS(DB)) bus1 ();

   assign bus0.i_en = en;   assign bus1.i_en = en;
   assign bus0.i_addr = addr; assign bus1.i_addr = addr;
   assign bus0.i_data = data; assign bus1.i_data = data;
   assign bus0.o_stall = stall; assign bus1.o_stall = stall;

   cdwa #(.NCH(NCH), .BANKBITS(BB), .WORDBITS(WB), .DATABITS(DB), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .cnt_clr(clr), .o_conflicts(conf0));
   cdwa #(.NCH(NCH), .BANKBITS(BB), .WORDBITS(WB), .DATABITS(DB), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .cnt_clr(clr), .o_conflicts(conf1));

   always #5 clk = ~clk;

   logic [NCH-1:0] g_a[2];
   logic           oe_a[2];
   logic [A-1:0]   oa_a[2];
   logic [DB-1:0]  od_a[2];
   logic [CW-1:0]  oc_a[2];
   logic [15:0]    cf_a[2];
   assign g_a[0] = bus0.i_grnt;  assign g_a[1] = bus1.i_grnt;
   assign oe_a[0] = bus0.o_en;   assign oe_a[1] = bus1.o_en;
   assign oa_a[0] = bus0.o_addr; assign oa_a[1] = bus1.o_addr;
   assign od_a[0] = bus0.o_data; assign od_a[1] = bus1.o_data;
   assign oc_a[0] = bus0.o_chan; assign oc_a[1] = bus1.o_chan;
   assign cf_a[0] = conf0;       assign cf_a[1] = conf1;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arbitration straight from the rules: scan order depends on mode.
   function automatic int pick(input int mode, input logic [NCH-1:0] e, input int p);
      if (mode == 0) begin
         for (int k = 0; k < NCH; k++) if (e[k]) return k;
      end else begin
         for (int s = 1; s <= NCH; s++) begin
            int c;
            c = (p + s) % NCH;
            if (e[c]) return c;
         end
      end
      return -1;
   endfunction

   logic          m_en[2],   p_en[2];
   logic [A-1:0]  m_addr[2], p_addr[2];
   logic [DB-1:0] m_data[2], p_data[2];
   int            m_chan[2], p_chan[2];
   int            m_ptr[2],  p_ptr[2];
   int            m_cnt[2],  p_cnt[2];

   always @(posedge clk or negedge rst_n) begin
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            m_en[m] = 1'b0; m_addr[m] = '0; m_data[m] = '0;
            m_chan[m] = 0; m_ptr[m] = NCH - 1; m_cnt[m] = 0;
         end else begin
            m_en[m] = p_en[m]; m_addr[m] = p_addr[m]; m_data[m] = p_data[m];
            m_chan[m] = p_chan[m]; m_ptr[m] = p_ptr[m]; m_cnt[m] = p_cnt[m];
         end
      end
   end

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         int w;
         logic [NCH-1:0] g_exp;
         w = pick(m, en, m_ptr[m]);
         g_exp = '0;
         if (rst_n && !stall && w >= 0) g_exp[w] = 1'b1;
         check($sformatf("m%0d grant", m), 64'(g_a[m]), 64'(g_exp));
         check($sformatf("m%0d o_en", m), 64'(oe_a[m]), 64'(m_en[m]));
         check($sformatf("m%0d o_addr", m), 64'(oa_a[m]), 64'(m_addr[m]));
         check($sformatf("m%0d o_data", m), 64'(od_a[m]), 64'(m_data[m]));
         check($sformatf("m%0d o_chan", m), 64'(oc_a[m]), 64'(m_chan[m]));
         check($sformatf("m%0d conflicts", m), 64'(cf_a[m]), 64'(m_cnt[m]));
         p_en[m] = m_en[m]; p_addr[m] = m_addr[m]; p_data[m] = m_data[m];
         p_chan[m] = m_chan[m]; p_ptr[m] = m_ptr[m]; p_cnt[m] = m_cnt[m];
         if (!stall) begin
            if (w >= 0) begin
               p_en[m] = 1'b1;
               p_addr[m] = addr[w*A +: A];
               p_data[m] = data[w*DB +: DB];
               p_chan[m] = w;
               if (m == 1) p_ptr[m] = w;
            end else begin
               p_en[m] = 1'b0;
            end
         end
         if (clr) p_cnt[m] = 0;
         else if (!stall && $countones(en) >= 2 && m_cnt[m] < 65535) p_cnt[m] = m_cnt[m] + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_payload();
      logic [63:0] ra;
      logic [95:0] rd;
      ra = {$urandom, $urandom};
      rd = {$urandom, $urandom, $urandom};
      addr = ra[NCH*A-1:0];
      data = rd;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("rst o_en", 64'(bus1.o_en), 64'd0);
      check("rst o_chan", 64'(bus1.o_chan), 64'd0);
      check("rst conflicts", 64'(conf1), 64'd0);
      check("rst grant", 64'(bus1.i_grnt), 64'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NCH-1:0] rr_exp [6];
      rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      #1 rst_n = 1'b0;
      #2;
      check("reset grant", 64'(bus0.i_grnt), 64'd0);
      check("reset o_en", 64'(bus0.o_en), 64'd0);
      check("reset conflicts", 64'(conf0), 64'd0);
      tick();
      rst_n = 1'b1;

      // fixed priority, channels 1 and 2 contending
      en = 3'b110; rand_payload();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("fp grant 110", 64'(bus0.i_grnt), 64'b010);
         tick();
         check("fp o_chan", 64'(bus0.o_chan), 64'd1);
         check("fp o_en", 64'(bus0.o_en), 64'd1);
      end
      check("fp conflicts", 64'(conf0), 64'd3);

      pulse_reset();
      en = 3'b111;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rr grant 111", 64'(bus1.i_grnt), 64'(rr_exp[i]));
         tick();
         check("rr o_chan", 64'(bus1.o_chan), 64'(i % 3));
      end

      en = 3'b011; stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("stall grant rr", 64'(bus1.i_grnt), 64'd0);
         check("stall grant fp", 64'(bus0.i_grnt), 64'd0);
         tick();
         check("stall o_chan", 64'(bus1.o_chan), 64'd2);
         check("stall o_en", 64'(bus1.o_en), 64'd1);
         check("stall conflicts", 64'(conf1), 64'd6);
      end
      stall = 1'b0;
      @(negedge clk);
      check("unstall grant", 64'(bus1.i_grnt), 64'b001);
      tick();

      en = 3'b101;
      @(negedge clk);
      check("rr skip to 2", 64'(bus1.i_grnt), 64'b100);
      tick();
      @(negedge clk);
      check("rr wrap to 0", 64'(bus1.i_grnt), 64'b001);
      tick();

      pulse_reset();
      en = 3'b111;
      @(negedge clk);
      check("post-reset rr grant", 64'(bus1.i_grnt), 64'b001);
      tick();

      for (int i = 0; i < 400; i++) begin
         en = NCH'($urandom);
         rand_payload();
         stall = ($urandom_range(0, 4) == 0);
         clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 99) == 0) begin
            #1;
            pulse_reset();
         end
         tick();
      end

      stall = 1'b0; clr = 1'b0; en = 3'b111;
      pulse_reset();
      repeat (65534) tick();
      check("sat preload", 64'(conf0), 64'hfffe);
      repeat (3) tick();
      check("sat fp", 64'(conf0), 64'hffff);
      check("sat rr", 64'(conf1), 64'hffff);
      clr = 1'b1;
      tick();
      check("clr over inc", 64'(conf0), 64'd0);
      clr = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
